// File: rtl/game_ctrl.sv
// game_ctrl: bird game sequencer (start/play/die/over, BCD score); GAME_CTRL_HISCORE_EN adds best-score tracking
module game_ctrl #(
    parameter int GO_DELAY  = 20,
    parameter int OVER_HOLD = 10
) (
    input  logic        clk_10,
    input  logic        clr,
    input  logic        start,
    input  logic        hit,
    input  logic        score_tick,
    output logic        tube_clr,
    output logic        over,
    output logic        running,
    output logic [15:0] score,
    output logic [15:0] best
);
    typedef enum logic [2:0] {IDLE, READY, PLAY, DYING, OVER} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] score_n;
    logic        start_q, start_rise;

    assign start_rise = start & ~start_q;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // next-state, delay counter and score update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        score_n = score;
        case (state)
            IDLE, OVER: if (start_rise) begin
                state_n = READY;
                cnt_n   = 8'(GO_DELAY - 1);
                score_n = 16'h0000;
            end
            READY: if (cnt == 8'd0) state_n = PLAY; else cnt_n = cnt - 8'd1;
            PLAY: if (hit) begin
                state_n = DYING;
                cnt_n   = 8'(OVER_HOLD - 1);
            end else if (score_tick) score_n = bcd_inc(score);
            DYING: if (cnt == 8'd0) state_n = OVER; else cnt_n = cnt - 8'd1;
            default: state_n = IDLE;
        endcase
    end

    // state, counter, score and registered control outputs
    always_ff @(posedge clk_10 or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            score    <= 16'h0000;
            start_q  <= 1'b0;
            tube_clr <= 1'b1;
            over     <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            score    <= score_n;
            start_q  <= start;
            tube_clr <= (state_n == IDLE) || (state_n == READY);
            over     <= (state_n == DYING) || (state_n == OVER);
            running  <= state_n == PLAY;
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    // capture a new best when a game ends; score is frozen during DYING
    always_ff @(posedge clk_10 or posedge clr) begin
        if (clr) best <= 16'h0000;
        else if (state == DYING && state_n == OVER && score > best) best <= score;
    end
`else
    assign best = 16'h0000;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: table vectors, directed corner cases and random stimulus against a behavioural model of game_ctrl
module tb_game_ctrl;
    localparam int GO = 20;
    localparam int OH = 10;
    localparam int M_IDLE = 0, M_READY = 1, M_PLAY = 2, M_DYING = 3, M_OVER = 4;

    logic        clk_10 = 1'b0, clr = 1'b0, start = 1'b0, hit = 1'b0, score_tick = 1'b0;
    logic        tube_clr, over, running;
    logic [15:0] score, best;

    game_ctrl #(.GO_DELAY(GO), .OVER_HOLD(OH)) dut (
        .clk_10(clk_10), .clr(clr), .start(start), .hit(hit), .score_tick(score_tick),
        .tube_clr(tube_clr), .over(over), .running(running), .score(score), .best(best)
    );

    always #5 clk_10 = ~clk_10;

    int checks = 0, errors = 0;
    int m_mode, m_rem, m_score, m_best;
    logic m_prev;

    typedef struct {
        logic s, h, t;
        int n;
        logic e_tc, e_ov, e_run;
        logic [15:0] e_sc;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rem = 0; m_score = 0; m_best = 0; m_prev = 1'b0;
    endtask

    task automatic check_model();
        chk("tube_clr", 16'(tube_clr), 16'(m_mode == M_IDLE || m_mode == M_READY));
        chk("over", 16'(over), 16'(m_mode == M_DYING || m_mode == M_OVER));
        chk("running", 16'(running), 16'(m_mode == M_PLAY));
        chk("score", score, bcd(m_score));
`ifdef GAME_CTRL_HISCORE_EN
        chk("best", best, bcd(m_best));
`else
        chk("best", best, 16'h0000);
`endif
    endtask

    // one clock: drive inputs, advance the model, compare just after the edge
    task automatic cyc(input logic s, input logic h, input logic t);
        logic rise;
        start = s; hit = h; score_tick = t;
        rise = s && !m_prev;
        m_prev = s;
        case (m_mode)
            M_IDLE, M_OVER: if (rise) begin m_mode = M_READY; m_rem = GO; m_score = 0; end
            M_READY: begin m_rem--; if (m_rem == 0) m_mode = M_PLAY; end
            M_PLAY: if (h) begin m_mode = M_DYING; m_rem = OH; end
                    else if (t && m_score < 9999) m_score++;
            default: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = M_OVER;
                    if (m_score > m_best) m_best = m_score;
                end
            end
        endcase
        @(posedge clk_10); #1;
        check_model();
    endtask

    task automatic do_reset();
        clr = 1'b1; start = 0; hit = 0; score_tick = 0;
        repeat (3) @(posedge clk_10);
        #1;
        model_reset();
        check_model();
        clr = 1'b0;
    endtask

    task automatic play_game(input int n);
        cyc(1, 0, 0);
        repeat (GO) cyc(0, 0, 0);
        repeat (n) cyc(0, 0, 1);
        cyc(0, 1, 0);
        repeat (OH) cyc(0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 10, 1, 0, 0, 16'h0000};
        tbl[1]  = '{1, 0, 0, 1,  1, 0, 0, 16'h0000};
        tbl[2]  = '{0, 0, 0, 18, 1, 0, 0, 16'h0000};
        tbl[3]  = '{0, 0, 0, 1,  1, 0, 0, 16'h0000};
        tbl[4]  = '{0, 0, 0, 1,  0, 0, 1, 16'h0000};
        tbl[5]  = '{0, 0, 1, 5,  0, 0, 1, 16'h0005};
        tbl[6]  = '{0, 1, 1, 1,  0, 1, 0, 16'h0005};
        tbl[7]  = '{1, 0, 0, 1,  0, 1, 0, 16'h0005};
        tbl[8]  = '{1, 0, 0, 15, 0, 1, 0, 16'h0005};
        tbl[9]  = '{0, 0, 0, 1,  0, 1, 0, 16'h0005};
        tbl[10] = '{1, 0, 0, 1,  1, 0, 0, 16'h0000};
        tbl[11] = '{0, 0, 0, 20, 0, 0, 1, 16'h0000};
        tbl[12] = '{0, 0, 1, 110, 0, 0, 1, 16'h0110};
        tbl[13] = '{0, 1, 0, 1,  0, 1, 0, 16'h0110};
        tbl[14] = '{0, 0, 0, 12, 0, 1, 0, 16'h0110};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            repeat (tbl[i].n) cyc(tbl[i].s, tbl[i].h, tbl[i].t);
            chk($sformatf("tbl%0d_tube_clr", i), 16'(tube_clr), 16'(tbl[i].e_tc));
            chk($sformatf("tbl%0d_over", i), 16'(over), 16'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_running", i), 16'(running), 16'(tbl[i].e_run));
            chk($sformatf("tbl%0d_score", i), score, tbl[i].e_sc);
        end

        do_reset();
        play_game(12);
`ifdef GAME_CTRL_HISCORE_EN
        chk("best_game1", best, 16'h0012);
        play_game(7);
        chk("best_game2", best, 16'h0012);
        play_game(30);
        chk("best_game3", best, 16'h0030);
`else
        chk("best_game1", best, 16'h0000);
        play_game(7);
        chk("best_game2", best, 16'h0000);
        play_game(30);
        chk("best_game3", best, 16'h0000);
`endif

        cyc(1, 0, 0);
        repeat (GO) cyc(0, 0, 0);
        repeat (9998) cyc(0, 0, 1);
        chk("score_9998", score, 16'h9998);
        repeat (3) cyc(0, 0, 1);
        chk("score_sat", score, 16'h9999);
        cyc(0, 1, 0);
        repeat (OH) cyc(0, 0, 0);

        cyc(1, 0, 0);
        repeat (GO) cyc(0, 0, 0);
        repeat (42) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        chk("score_42", score, 16'h0042);
        #2 clr = 1'b1;
        #1;
        chk("async_score", score, 16'h0000);
        chk("async_best", best, 16'h0000);
        chk("async_tube_clr", 16'(tube_clr), 16'h0001);
        chk("async_running", 16'(running), 16'h0000);
        model_reset();
        @(posedge clk_10); #1;
        clr = 1'b0;

        repeat (3000) cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
